// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Fetch controller states; encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Word-align a branch/jump target by clearing the byte offset bits.
  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(32'h3);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter and pending-redirect target registers.
// Both load only when their load strobe is high; synchronous active-low reset.
module fetch_pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  pc_load,
  input  word_t pc_next,
  input  logic  pend_load,
  input  word_t pend_next,
  output word_t pc,
  output word_t pending_pc
);

  // pc and pending_pc update independently under their own load strobes
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc         <= PC_INIT;
      pending_pc <= '0;
    end else begin
      if (pc_load) begin
        pc <= pc_next;
      end
      if (pend_load) begin
        pending_pc <= pend_next;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// drives the IF/ID latch enable/flush. A redirect that arrives while a read
// is still outstanding parks the target in pending_pc (DRAIN) until that
// read completes, so memory never sees an abandoned request.
// Optional feature macro: FETCH_PERF_EN adds fetch_count/bubble_count.
//
// IF/ID handshake: ifid_en=1 means the latch captures this cycle; when
// ifid_flush=1 as well it captures a zero bubble instead of the word.
// ifid_en=0 holds the latch (stall). The word is valid only with ihit=1.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         ihit,
  input  word_t        imemload,
  output logic         iREN,
  output word_t        iaddr,
  input  logic         stall,
  input  logic         redirect,
  input  word_t        redirect_pc,
  input  logic         halt,
  output logic         ifid_en,
  output logic         ifid_flush,
  output word_t        imemload_out,
  output word_t        pcp4_out,
  output fetch_state_t state
`ifdef FETCH_PERF_EN
  ,
  output word_t        fetch_count,
  output word_t        bubble_count
`endif
);

  fetch_state_t state_next;
  word_t        pc;
  word_t        pending_pc;
  word_t        target;
  logic         pc_load;
  word_t        pc_next;
  logic         pend_load;
  word_t        pend_next;

  fetch_pc_reg #(
    .PC_INIT(PC_INIT)
  ) u_pc_reg (
    .CLK       (CLK),
    .nRST      (nRST),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .pend_load (pend_load),
    .pend_next (pend_next),
    .pc        (pc),
    .pending_pc(pending_pc)
  );

  assign target       = align_word(redirect_pc);
  assign iaddr        = pc;
  assign imemload_out = imemload;
  assign pcp4_out     = pc + PC_STEP;

  // Next-state, PC update and IF/ID control; priority halt > redirect > stall > ihit
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_next    = pc;
    pend_load  = 1'b0;
    pend_next  = pending_pc;
    iREN       = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b1;
    if (nRST) begin
      case (state)
        FETCH: begin
          if (halt) begin
            state_next = HALTED;
          end else if (redirect) begin
            if (ihit) begin
              pc_load = 1'b1;
              pc_next = target;
            end else begin
              // read to the old pc still in flight: wait for it first
              pend_load  = 1'b1;
              pend_next  = target;
              state_next = DRAIN;
            end
          end else if (stall) begin
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
          end else if (ihit) begin
            pc_load    = 1'b1;
            pc_next    = pc + PC_STEP;
            ifid_flush = 1'b0;
          end
        end
        DRAIN: begin
          if (halt) begin
            state_next = HALTED;
          end else if (ihit) begin
            // returned word belongs to the old path and is discarded
            pc_load    = 1'b1;
            pc_next    = redirect ? target : pending_pc;
            state_next = FETCH;
          end else if (redirect) begin
            pend_load = 1'b1;
            pend_next = target;
          end
        end
        HALTED: begin
          iREN = 1'b0;
        end
        default: begin
          state_next = FETCH;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-fetch and bubble counters, free-running with wrap
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (state == FETCH && ihit && !stall) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (ifid_flush && state != HALTED) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a driver issues one input vector per cycle
// and pushes the hand-computed expected outputs; a monitor pops and compares.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam int W = 101;

  logic         CLK;
  logic         nRST;
  logic         ihit;
  word_t        imemload;
  logic         iREN;
  word_t        iaddr;
  logic         stall;
  logic         redirect;
  word_t        redirect_pc;
  logic         halt;
  logic         ifid_en;
  logic         ifid_flush;
  word_t        imemload_out;
  word_t        pcp4_out;
  fetch_state_t state;
`ifdef FETCH_PERF_EN
  word_t        fetch_count;
  word_t        bubble_count;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;
  int           step_no;

  fetch_unit #(
    .PC_INIT(32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .imemload_out(imemload_out),
    .pcp4_out    (pcp4_out),
    .state       (state)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    nRST        = 1'b0;
    ihit        = 1'b0;
    imemload    = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
  end

  // Driver: apply one cycle of inputs just after the edge; queue expectations
  task automatic step(input string nm, input logic chk, input logic nrst_i,
                      input logic ihit_i, input logic stall_i, input logic redir_i,
                      input word_t rpc_i, input logic halt_i, input logic e_iren,
                      input word_t e_iaddr, input logic e_en, input logic e_flush,
                      input logic [1:0] e_state);
    word_t e_pcp4;
    word_t word;
    @(posedge CLK);
    #1;
    step_no     = step_no + 1;
    word        = 32'hA000_0000 + word_t'(step_no);
    nRST        = nrst_i;
    ihit        = ihit_i;
    imemload    = word;
    stall       = stall_i;
    redirect    = redir_i;
    redirect_pc = rpc_i;
    halt        = halt_i;
    e_pcp4      = e_iaddr + 32'd4;
    if (chk) begin
      exp_q.push_back({e_state, e_iren, e_iaddr, e_en, e_flush, e_pcp4, word});
      name_q.push_back(nm);
    end
  endtask

  // Monitor / scoreboard: compare observed outputs mid-cycle
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    string        nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp_v  = exp_q.pop_front();
        nm     = name_q.pop_front();
        act_v  = {2'(state), iREN, iaddr, ifid_en, ifid_flush, pcp4_out, imemload_out};
        checks = checks + 1;
        if (act_v !== exp_v) begin
          errors = errors + 1;
          $display("FAIL %s: got state=%0d iREN=%b iaddr=%h en=%b flush=%b pcp4=%h word=%h ; expected state=%0d iREN=%b iaddr=%h en=%b flush=%b pcp4=%h word=%h",
                   nm, act_v[100:99], act_v[98], act_v[97:66], act_v[65], act_v[64],
                   act_v[63:32], act_v[31:0], exp_v[100:99], exp_v[98], exp_v[97:66],
                   exp_v[65], exp_v[64], exp_v[63:32], exp_v[31:0]);
        end
      end
    end
  end

  // Stimulus: F=0 D=1 H=2
  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    //    name            chk nrst ihit stl red rpc           hlt  iren iaddr         en fl st
    step("rst0",          0,  0,   1,   0,  0,  32'h0,        0,   1,   32'h0,        1, 1, 0);
    step("rst1",          1,  0,   1,   0,  0,  32'h0,        0,   1,   32'h0,        1, 1, 0);
    step("seq0",          1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h0,        1, 0, 0);
    step("seq4",          1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h4,        1, 0, 0);
    step("stall8a",       1,  1,   1,   1,  0,  32'h0,        0,   1,   32'h8,        0, 0, 0);
    step("stall8b",       1,  1,   1,   1,  0,  32'h0,        0,   1,   32'h8,        0, 0, 0);
    step("seq8",          1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h8,        1, 0, 0);
    step("seqC",          1,  1,   1,   0,  0,  32'h0,        0,   1,   32'hC,        1, 0, 0);
    step("redir_hit",     1,  1,   1,   0,  1,  32'h103,      0,   1,   32'h10,       1, 1, 0);
    step("tgt100",        1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h100,      1, 0, 0);
    step("redir_to20",    1,  1,   1,   0,  1,  32'h20,       0,   1,   32'h104,      1, 1, 0);
    step("drain_enter",   1,  1,   0,   0,  1,  32'h40,       0,   1,   32'h20,       1, 1, 0);
    step("drain1",        1,  1,   0,   0,  0,  32'h0,        0,   1,   32'h20,       1, 1, 1);
    step("drain2_redir",  1,  1,   0,   0,  1,  32'h83,       0,   1,   32'h20,       1, 1, 1);
    step("drain_hit",     1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h20,       1, 1, 1);
    step("tgt80",         1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h80,       1, 0, 0);
    step("redir84_miss",  1,  1,   0,   0,  1,  32'hC0,       0,   1,   32'h84,       1, 1, 0);
    step("drain_red_hit", 1,  1,   1,   0,  1,  32'hE0,       0,   1,   32'h84,       1, 1, 1);
    step("missE0",        1,  1,   0,   0,  0,  32'h0,        0,   1,   32'hE0,       1, 1, 0);
    step("redir_top",     1,  1,   1,   0,  1,  32'hFFFF_FFFF,0,   1,   32'hE0,       1, 1, 0);
    step("wrap",          1,  1,   1,   0,  0,  32'h0,        0,   1,   32'hFFFF_FFFC,1, 0, 0);
    step("after_wrap",    1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h0,        1, 0, 0);
    step("halt_redir",    1,  1,   1,   0,  1,  32'h200,      1,   1,   32'h4,        1, 1, 0);
    step("halted1",       1,  1,   1,   0,  1,  32'h300,      0,   0,   32'h4,        1, 1, 2);
    step("halted2",       1,  1,   1,   1,  0,  32'h0,        1,   0,   32'h4,        1, 1, 2);
    step("rst_halted",    1,  0,   1,   0,  0,  32'h0,        0,   1,   32'h4,        1, 1, 2);
    step("post_rst",      1,  1,   0,   0,  0,  32'h0,        0,   1,   32'h0,        1, 1, 0);
    step("fetch0",        1,  1,   1,   0,  0,  32'h0,        0,   1,   32'h0,        1, 0, 0);
    step("drain_pre_rst", 1,  1,   0,   0,  1,  32'h300,      0,   1,   32'h4,        1, 1, 0);
    step("rst_drain",     1,  0,   0,   0,  0,  32'h0,        0,   1,   32'h4,        1, 1, 1);
    step("post_rst2",     1,  1,   0,   0,  0,  32'h0,        0,   1,   32'h0,        1, 1, 0);
    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge CLK);
    end
    if (exp_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain_timeout: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
